// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation candidate scheduler.
package me_pkg;

  localparam int MV_W   = 14;
  localparam int SAD_W  = 16;
  localparam int HALF_W = MV_W / 2;

  // Scheduler FSM encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Horizontal component, packed in the low half.
  function automatic logic signed [HALF_W-1:0] mv_x(input logic [MV_W-1:0] mv);
    return $signed(mv[HALF_W-1:0]);
  endfunction

  // Vertical component, packed in the high half.
  function automatic logic signed [HALF_W-1:0] mv_y(input logic [MV_W-1:0] mv);
    return $signed(mv[MV_W-1:HALF_W]);
  endfunction

  // Saturate one signed component to [-lim, +lim].
  function automatic logic signed [HALF_W-1:0] mv_sat(input logic signed [HALF_W-1:0] v,
                                                      input int lim);
    int w;
    w = int'(v);
    if (w > lim)       w = lim;
    else if (w < -lim) w = -lim;
    return HALF_W'(w);
  endfunction

  // Clamp x and y independently to the search range.
  function automatic logic [MV_W-1:0] mv_clamp(input logic [MV_W-1:0] mv, input int lim);
    return {mv_sat(mv_y(mv), lim), mv_sat(mv_x(mv), lim)};
  endfunction

endpackage

// File: rtl/mv_inflight_fifo.sv
// Holds issued MVs until their SADs return in order; supports push and pop in one cycle.
module mv_inflight_fifo
  import me_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = MV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; occupancy is tracked by count, so stale words are never read as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/me_candidate_scheduler.sv
// Per-block candidate scheduler: clamp, dedupe, issue candidates, pick the minimum-SAD vector.
module me_candidate_scheduler
  import me_pkg::*;
#(
  parameter int NUM_CAND = 6,
  parameter int RANGE    = 24,
  parameter int FIFO_D   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CAND*MV_W-1:0] cand_in,
  input  logic [NUM_CAND-1:0]      cand_mask,
  output logic [MV_W-1:0]          issue_mv,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  input  logic [SAD_W-1:0]         sad_in,
  input  logic                     sad_valid,
  output logic [MV_W-1:0]          best_mv,
  output logic [SAD_W-1:0]         best_sad,
  output logic                     done,
  output logic                     busy,
  output logic                     err_sad
);
  localparam int IW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

  state_t              state;
  logic [MV_W-1:0]     cand_q  [NUM_CAND];
  logic [MV_W-1:0]     clamped [NUM_CAND];
  logic [NUM_CAND-1:0] mask_q, rem_mask, eff_mask, rem_next;
  logic [IW-1:0]       cur_idx;
  logic [SAD_W-1:0]    min_sad;
  logic [MV_W-1:0]     min_mv;
  logic [MV_W-1:0]     fifo_head;
  logic                fifo_full, fifo_empty, issue_fire, sad_pop;

  // Clamp every slot and drop masked slots or repeats of a lower, still-enabled slot.
  // NOTE: every output of this block gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    eff_mask = mask_q;
    for (int i = 0; i < NUM_CAND; i++) begin
      clamped[i] = mv_clamp(cand_q[i], RANGE);
    end
    for (int i = 1; i < NUM_CAND; i++) begin
      for (int j = 0; j < i; j++) begin
        if (eff_mask[j] && (clamped[j] == clamped[i])) eff_mask[i] = 1'b0;
      end
    end
  end

  // Pick the lowest remaining slot and precompute the mask after it is issued.
  always_comb begin
    cur_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (rem_mask[i]) cur_idx = IW'(i);
    end
    rem_next          = rem_mask;
    rem_next[cur_idx] = 1'b0;
  end

  assign issue_valid = (state == ISSUE) && !fifo_full;
  assign issue_mv    = (state == ISSUE) ? cand_q[cur_idx] : '0;
  assign issue_fire  = issue_valid && issue_ready;
  assign sad_pop     = sad_valid && !fifo_empty;
  assign busy        = (state != IDLE);

  mv_inflight_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (MV_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue_fire),
    .push_data (issue_mv),
    .pop       (sad_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Block FSM, running minimum and error flag.
  // NOTE: all state here uses non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      for (int i = 0; i < NUM_CAND; i++) cand_q[i] <= '0;
      mask_q   <= '0;
      rem_mask <= '0;
      min_sad  <= '1;
      min_mv   <= '0;
      best_mv  <= '0;
      best_sad <= '1;
      done     <= 1'b0;
      err_sad  <= 1'b0;
    end else begin
      done <= 1'b0;

      // Results return in issue order; strict compare lets the earlier candidate keep ties.
      if (sad_pop && (sad_in < min_sad)) begin
        min_sad <= sad_in;
        min_mv  <= fifo_head;
      end
      if (sad_valid && fifo_empty) err_sad <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_CAND; i++) cand_q[i] <= cand_in[i*MV_W +: MV_W];
            mask_q  <= cand_mask;
            min_sad <= '1;
            min_mv  <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          for (int i = 0; i < NUM_CAND; i++) cand_q[i] <= clamped[i];
          rem_mask <= eff_mask;
          if (eff_mask == '0) begin
            best_mv  <= min_mv;
            best_sad <= min_sad;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            rem_mask <= rem_next;
            if (rem_next == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            best_mv  <= min_mv;
            best_sad <= min_sad;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/me_candidate_scheduler.md
Name: me_candidate_scheduler

Overview:
Per-block candidate scheduler for the 3D recursive-search motion estimator. On each block start it latches up to NUM_CAND candidate motion vectors (spatial, temporal and update vectors). It clamps each one to the search range and drops masked and duplicate entries. It then issues the survivors one at a time to the search-window address generator / SAD engine under a valid/ready handshake, pairs the in-order returning SADs with their vectors, and reports the minimum-SAD vector with a one-cycle done pulse.

Parameters:
MV_W, 14, packed MV width: {y[6:0], x[6:0]}, each half two's complement
SAD_W, 16, SAD width
NUM_CAND, 6, candidate slots per block
RANGE, 24, clamp limit; each component is saturated to [-RANGE, +RANGE]
FIFO_D, 4, depth of the in-flight MV FIFO; must be at least the SAD pipeline latency plus 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin a block; ignored while busy=1
cand_in  in  NUM_CAND*MV_W  candidate vectors, slot 0 in the LSBs; sampled on start
cand_mask  in  NUM_CAND  1 = slot is used; sampled on start
issue_mv  out  MV_W  clamped candidate sent to the address generator
issue_valid  out  1  issue_mv is valid
issue_ready  in  1  address generator / update window accepts the candidate
sad_in  in  SAD_W  SAD result
sad_valid  in  1  sad_in is valid; results return in issue order
best_mv  out  MV_W  winning vector; held until the next done
best_sad  out  SAD_W  winning SAD; held until the next done
done  out  1  one-cycle pulse; best_* are valid in the same cycle
busy  out  1  high from the cycle after start until the cycle of done, inclusive
err_sad  out  1  sticky flag: sad_valid arrived with nothing in flight; cleared by reset only

Behaviour:
- Reset values (reset=0, asynchronous): state IDLE, issue_valid=0, issue_mv=0, best_mv=0, best_sad=all-ones, done=0, busy=0, err_sad=0, FIFO empty, outstanding count 0.
- Reset asserted mid-block aborts the block immediately. No done is produced, and any later sad_valid for that block sets err_sad.
- FSM states: IDLE -> LOAD -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: on start, register cand_in and cand_mask, clear the running minimum to all-ones / MV 0, set index to 0, go to LOAD.
- LOAD (1 cycle): clamp each slot per component, x and y independently: values > RANGE become RANGE, values < -RANGE become -RANGE. Build an effective mask. A slot is dropped if its mask bit is 0 or if its clamped MV equals a lower-index, still-enabled slot. Go to ISSUE, or straight to DONE if the effective mask is all zero.
- ISSUE:
  - issue_valid=1 with issue_mv = next enabled slot in ascending index order.
  - issue_valid is deasserted only when the FIFO is full (FIFO_D in-flight entries).
  - issue_mv must stay stable while issue_valid=1 and issue_ready=0.
  - On issue_valid & issue_ready: push the MV into the FIFO and advance to the next enabled slot.
  - After the last accepted issue, go to DRAIN.
- SAD handling, in any state: on sad_valid with the FIFO non-empty, pop the MV. If sad_in < running minimum (strictly less), replace the minimum and its MV, so the earlier candidate wins ties. A pop and a push in the same cycle are legal and leave the occupancy unchanged.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE (1 cycle): drive best_mv/best_sad from the running minimum, pulse done=1, busy=0 from the next cycle, return to IDLE.
  - With no enabled candidates: best_mv=0, best_sad=all-ones.
- Latency: start to done = 3 + issued candidates + SAD pipeline latency, with issue_ready held at 1.
- start in the DONE cycle is ignored. start in IDLE in the cycle after done is accepted.
- sad_valid with the FIFO empty: the result is discarded and err_sad is set.

Decomposition:
- Shared package me_pkg:
  - constants MV_W and SAD_W
  - helper functions mv_x / mv_y (field extract) and mv_clamp (per-component saturation)
  - state encoding localparams: IDLE=0, LOAD=1, ISSUE=2, DRAIN=3, DONE=4
- Sub-module mv_inflight_fifo (FIFO_D x MV_W, synchronous, asynchronous active-low reset): push, pop, full, empty and head output, with simultaneous push/pop supported.

Test Plan:
- Basic: mask=6'b000111 with MVs (1,1), (2,-3), (0,0); SADs 40, 12, 12 returned 3 cycles after each issue; issue_ready=1 -> three issues in consecutive cycles, done with best_mv=(2,-3), best_sad=12 (tie goes to the earlier candidate), done 9 cycles after start.
- Clamp and duplicate: slots (30,-40) and (24,-24) -> both clamp to (24,-24), only one issue occurs, done follows its single SAD.
- Empty mask: start with mask=0 -> no issue_valid, done 2 cycles after start, best_mv=0, best_sad=16'hFFFF.
- Backpressure: issue_ready low for 5 cycles with 6 candidates -> issue_mv stable throughout, issue_valid drops when 4 are in flight, all 6 SADs are consumed, winner is correct.
- Errors and ignored starts: sad_valid while IDLE -> err_sad=1 and stays set; start pulsed during ISSUE -> ignored, no second done.
- Reset mid-block: reset=0 during DRAIN -> all outputs return to reset values asynchronously; a new start then completes normally.
